// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: synchronises rx, validates the start bit mid-bit,
// samples an LSB-first data word and checks the stop bit. Parity via `UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud16_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [3:0] MID_TICK  = 4'd7;
    localparam logic [3:0] LAST_TICK = 4'd15;

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx: DATA_BITS must be 5..9 and PARITY_ODD 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [3:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
`ifdef UART_RX_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    logic                 par_q, par_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
`endif

        if (baud16_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end

                S_START: begin
                    if (cnt_q == MID_TICK) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end

                S_DATA: begin
                    if (cnt_q == LAST_TICK) begin
                        // Shift in from the top: after DATA_BITS samples the first bit sits at bit 0.
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        cnt_d   = '0;
                        if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == LAST_TICK) begin
                        par_d   = rx_s_q;
                        cnt_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`endif

                S_STOP: begin
                    if (cnt_q == LAST_TICK) begin
                        rx_data_d = shift_q;
                        cnt_d     = '0;
                        if (rx_s_q) begin
                            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = ((^shift_q) ^ par_q) != ODD;
`endif
                            state_d = S_IDLE;
                        end else begin
                            // A low stop bit may be a break; wait for the line to idle before rearming.
                            frame_err_d = 1'b1;
                            state_d     = S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end

                S_WAIT_HIGH: begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clk, 64 clk per bit; expected words are
// queued as frames are sent and compared when the receiver pulses.
module tb_uart_rx;

    localparam int DATA_BITS = 8;
    localparam int BIT_CLKS  = 64;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 baud16_tick = 1'b0;
    logic                 rx = 1'b1;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    typedef struct {
        logic                 ferr;
        logic [DATA_BITS-1:0] data;
        logic                 perr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total    = 0;
    int   bad      = 0;
    int   n_events = 0;
    int   n_pushed = 0;
    int   ev_before;

    uart_rx #(.DATA_BITS(DATA_BITS), .PARITY_ODD(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud16_tick(baud16_tick),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            baud16_tick = 1'b1;
            @(negedge clk);
            baud16_tick = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
    endtask

    task automatic expect_word(input logic [DATA_BITS-1:0] d, input logic perr);
        sb.push_back('{ferr: 1'b0, data: d, perr: perr});
        n_pushed++;
    endtask

    task automatic expect_ferr(input logic [DATA_BITS-1:0] d);
        sb.push_back('{ferr: 1'b1, data: d, perr: 1'b0});
        n_pushed++;
    endtask

    // Any output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && (rx_valid || frame_err || parity_err)) begin
            n_events++;
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("pulse_kind", 32'({rx_valid, frame_err}), mon_e.ferr ? 32'd1 : 32'd2);
                check("rx_data", 32'(rx_data), 32'(mon_e.data));
                check("parity_err", 32'(parity_err), 32'(mon_e.perr));
            end
        end
    end

    initial begin
        rst = 1'b0;
        wait_clks(4);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_parity_err", 32'(parity_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        wait_clks(32);

        expect_word(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1);
        wait_clks(32);
        check("a5_busy_low", 32'(busy), 32'h0);
        check("a5_data_held", 32'(rx_data), 32'hA5);

        expect_word(8'h3C, 1'b0);
        expect_word(8'hC3, 1'b0);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        wait_clks(64);
        check("b2b_event_count", 32'(n_events), 32'(n_pushed));
        check("b2b_data_held", 32'(rx_data), 32'hC3);

        ev_before = n_events;
        rx = 1'b0;
        wait_clks(20);
        check("glitch_busy_high", 32'(busy), 32'h1);
        rx = 1'b1;
        for (int i = 0; i < 32 && busy; i++) wait_clks(1);
        check("glitch_busy_low", 32'(busy), 32'h0);
        wait_clks(64);
        check("glitch_no_output", 32'(n_events), 32'(ev_before));

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b0;
        wait_clks(32);
        rst = 1'b0;
        rx  = 1'b1;
        wait_clks(2);
        check("midreset_rx_data", 32'(rx_data), 32'h0);
        check("midreset_rx_valid", 32'(rx_valid), 32'h0);
        check("midreset_frame_err", 32'(frame_err), 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        wait_clks(8);
        rst = 1'b1;
        wait_clks(64);
        expect_word(8'h5A, 1'b0);
        send_frame(8'h5A, 1'b1);
        wait_clks(32);
        check("post_reset_data", 32'(rx_data), 32'h5A);
        check("post_reset_event_count", 32'(n_events), 32'(n_pushed));

        expect_ferr(8'h00);
        send_frame(8'h00, 1'b0);
        wait_clks(3 * BIT_CLKS);
        check("break_busy_high", 32'(busy), 32'h1);
        check("break_single_event", 32'(n_events), 32'(n_pushed));
        rx = 1'b1;
        wait_clks(16);
        check("break_busy_low", 32'(busy), 32'h0);
        check("break_data_held", 32'(rx_data), 32'h00);

`ifdef UART_RX_PARITY_EN
        expect_word(8'h07, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) send_bit(i < 3);
        send_bit(1'b0);
        send_bit(1'b1);
        expect_word(8'h07, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) send_bit(i < 3);
        send_bit(1'b1);
        send_bit(1'b1);
        wait_clks(32);
        check("parity_event_count", 32'(n_events), 32'(n_pushed));
`endif

        wait_clks(64);
        check("sb_empty", 32'(sb.size()), 32'h0);
        check("final_event_count", 32'(n_events), 32'(n_pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

16x-oversampling UART receiver that sits directly downstream of the baud generator and consumes its `baud16_tick` strobe. It synchronises the asynchronous `rx` line, detects and validates start bits, mid-bit samples an LSB-first data frame, and checks the stop bit. It presents each received word as a one-cycle strobe to the consuming logic (FIFO or register file).

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `PARITY_ODD`, 0: selects the parity sense when `UART_RX_PARITY_EN` is defined. 0 = even, 1 = odd. Ignored otherwise.
- `clk`  in  1: system clock; single clock domain.
- `rst`  in  1: reset, asynchronous, active-low.
- `baud16_tick`  in  1: one-`clk` strobe at 16x the baud rate, from the baud generator.
- `rx`  in  1: serial line, asynchronous, idle high.
- `rx_data`  out  DATA_BITS: last received word; held until the next frame completes.
- `rx_valid`  out  1: one-`clk` pulse when a frame has a good stop bit.
- `frame_err`  out  1: one-`clk` pulse when the stop bit is sampled low.
- `parity_err`  out  1: one-`clk` pulse, coincident with `rx_valid`, when parity mismatches. Tied 0 without the macro.
- `busy`  out  1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser, reset to 1, producing `rx_s`. All decisions use `rx_s`.
- All state and counter changes happen only on `clk` edges where `baud16_tick`=1. The exception is the output pulses, which clear on the following `clk`.
- The FSM has states IDLE, START, DATA, PARITY (present only with the macro), STOP and WAIT_HIGH. It uses a 4-bit tick counter `cnt` and a bit index.
- IDLE: when a tick occurs with `rx_s`=0, go to START with `cnt`=0.
- START: `cnt` increments on each tick. When `cnt`=7 (mid start bit):
  - If `rx_s`=0, go to DATA with `cnt`=0 and bit index 0.
  - If `rx_s`=1, the start is false. Return to IDLE with no output.
- DATA: on the tick where `cnt`=15, sample `rx_s` into bit[index] (LSB first), set `cnt`=0 and increment index. After bit DATA_BITS-1, go to PARITY if enabled, otherwise STOP.
- PARITY: on `cnt`=15, sample the parity bit, then go to STOP.
- STOP: on `cnt`=15, sample the stop bit.
  - `rx_s`=1: load `rx_data`, pulse `rx_valid` (and `parity_err` if parity mismatched), go to IDLE.
  - `rx_s`=0: load `rx_data`, pulse `frame_err`, do not pulse `rx_valid`, go to WAIT_HIGH.
- WAIT_HIGH: stay until a tick with `rx_s`=1, then go to IDLE. This prevents a break condition from retriggering reception.
- A frame with a bad stop bit never also reports `parity_err`.
- The shift register is internal. `rx_data` changes only at frame completion.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, state=IDLE, `cnt`=0, synchroniser flops=1.
- Start detection latency is 2 `clk` (synchroniser) plus up to one tick period.
- Each data, parity and stop sample is taken 16 ticks after the previous sample. The first data sample is 16 ticks after the mid-start sample.
- `rx_valid`/`frame_err` rise on the `clk` edge of the stop-sample tick and fall on the next `clk` edge. They are exactly one cycle wide even if `baud16_tick` is held high.
- `busy` rises the `clk` after start detection and falls with the stop-sample edge, or on exit from WAIT_HIGH.
- Async reset mid-frame aborts immediately: outputs return to reset values and the partial word is discarded.
- After a good stop bit, the receiver is back in IDLE by the middle of the stop bit. A following start edge is therefore caught with at most 8 ticks of slack.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state is compiled in and the frame is start + DATA_BITS + parity + stop.
  - Even parity (`PARITY_ODD`=0) expects the XOR of data and parity bit to be 0; odd parity expects 1.
  - A mismatch pulses `parity_err` together with `rx_valid`.
- `UART_RX_PARITY_EN` undefined:
  - There is no PARITY state, the frame is start + DATA_BITS + stop, and `parity_err` is constant 0.

## Test plan
- Bench drives `baud16_tick` every 4 `clk` and `rx` at 64 `clk`/bit. Send 0xA5 with stop=1 -> one `rx_valid` pulse, `rx_data`=0xA5, `frame_err`=0.
- Send 0x3C and 0xC3 back-to-back with no idle gap -> two `rx_valid` pulses, data 0x3C then 0xC3.
- Send a 20-clk low glitch on idle `rx` -> no `rx_valid` or `frame_err`; `busy` returns to 0 within 8 ticks.
- Send 0x00 with the stop bit low, then hold `rx` low for 3 bit times -> one `frame_err` pulse, `rx_data`=0x00, no further activity until `rx` goes high.
- With `UART_RX_PARITY_EN`, `PARITY_ODD`=0, send 0x07 with parity bit 0 -> `rx_valid` and `parity_err` pulse together. Send 0x07 with parity bit 1 -> `rx_valid` only.
- Assert `rst` low during data bit 4 of a frame, then release and send 0x5A -> outputs 0 during reset, then `rx_data`=0x5A with one `rx_valid` pulse.
